// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Non-memory ops pass through with one cycle of latency. LOAD/STORE ops
// issue a request on the data-memory req/ack interface and stall upstream
// until the access completes.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access with
// no acknowledge is aborted after TIMEOUT_CYCLES cycles and mem_err pulses.
module mem_stage #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        control_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        dest_index_in,
    input  logic              reg_write_en_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_control,
    output logic              mem_err
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;

    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

    logic              r_wb_valid, w_wb_valid_nxt;
    logic              r_wb_we, w_wb_we_nxt;
    logic [4:0]        r_wb_dest, w_wb_dest_nxt;
    logic [DATA_W-1:0] r_wb_data, w_wb_data_nxt;
    logic [4:0]        r_wb_control, w_wb_control_nxt;

    // Instruction fields captured when the access is issued; upstream moves on.
    logic [4:0]        r_cap_dest, w_cap_dest_nxt;
    logic [4:0]        r_cap_ctrl, w_cap_ctrl_nxt;
    logic              r_cap_we, w_cap_we_nxt;

    logic              w_is_load;
    logic              w_is_store;
    logic [ADDR_W-1:0] w_addr_in;
    logic [DATA_W-1:0] w_addr_ext;

    // Address is the low ADDR_W bits of the ALU result, zero-extended when wider.
    if (ADDR_W <= DATA_W) begin : g_addr_narrow
        assign w_addr_in  = result_in[ADDR_W-1:0];
        assign w_addr_ext = DATA_W'(r_addr);
    end else begin : g_addr_wide
        assign w_addr_in  = ADDR_W'(result_in);
        assign w_addr_ext = r_addr[DATA_W-1:0];
    end

    assign w_is_load  = (control_in[3:0] == OP_LOAD);
    assign w_is_store = (control_in[3:0] == OP_STORE);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
    logic       r_mem_err, w_mem_err_nxt;
`endif

    // Next-state and next-output decode; every target defaults to hold or idle.
    always_comb begin
        w_state_nxt      = r_state;
        w_req_nxt        = r_req;
        w_we_nxt         = r_we;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wb_valid_nxt   = 1'b0;
        w_wb_we_nxt      = 1'b0;
        w_wb_dest_nxt    = r_wb_dest;
        w_wb_data_nxt    = r_wb_data;
        w_wb_control_nxt = r_wb_control;
        w_cap_dest_nxt   = r_cap_dest;
        w_cap_ctrl_nxt   = r_cap_ctrl;
        w_cap_we_nxt     = r_cap_we;
`ifdef MEM_TIMEOUT_EN
        w_wait_cnt_nxt   = r_wait_cnt;
        w_mem_err_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_is_load || w_is_store) begin
                    w_state_nxt    = ACCESS;
                    w_req_nxt      = 1'b1;
                    w_we_nxt       = w_is_store;
                    w_addr_nxt     = w_addr_in;
                    w_wdata_nxt    = store_data_in;
                    w_cap_dest_nxt = dest_index_in;
                    w_cap_ctrl_nxt = control_in;
                    w_cap_we_nxt   = reg_write_en_in;
`ifdef MEM_TIMEOUT_EN
                    w_wait_cnt_nxt = 8'd0;
`endif
                end else begin
                    w_wb_valid_nxt   = (control_in[3:0] != OP_NOP);
                    w_wb_we_nxt      = reg_write_en_in && (control_in[3:0] != OP_NOP);
                    w_wb_dest_nxt    = dest_index_in;
                    w_wb_data_nxt    = result_in;
                    w_wb_control_nxt = control_in;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    w_state_nxt      = IDLE;
                    w_req_nxt        = 1'b0;
                    w_wb_valid_nxt   = 1'b1;
                    w_wb_dest_nxt    = r_cap_dest;
                    w_wb_control_nxt = r_cap_ctrl;
                    if (r_we) begin
                        // A completed store reports its address, never writes a register.
                        w_wb_we_nxt   = 1'b0;
                        w_wb_data_nxt = w_addr_ext;
                    end else begin
                        w_wb_we_nxt   = r_cap_we;
                        w_wb_data_nxt = dmem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_wait_cnt == TMO_LAST) begin
                    w_state_nxt      = IDLE;
                    w_req_nxt        = 1'b0;
                    w_wb_valid_nxt   = 1'b1;
                    w_wb_we_nxt      = 1'b0;
                    w_wb_dest_nxt    = r_cap_dest;
                    w_wb_control_nxt = r_cap_ctrl;
                    w_mem_err_nxt    = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_dest    <= '0;
            r_wb_data    <= '0;
            r_wb_control <= '0;
            r_cap_dest   <= '0;
            r_cap_ctrl   <= '0;
            r_cap_we     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wb_valid   <= w_wb_valid_nxt;
            r_wb_we      <= w_wb_we_nxt;
            r_wb_dest    <= w_wb_dest_nxt;
            r_wb_data    <= w_wb_data_nxt;
            r_wb_control <= w_wb_control_nxt;
            r_cap_dest   <= w_cap_dest_nxt;
            r_cap_ctrl   <= w_cap_ctrl_nxt;
            r_cap_we     <= w_cap_we_nxt;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter and one-cycle timeout error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign mem_err = 1'b0;
`endif

    assign stall      = (r_state == ACCESS);
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign wb_dest    = r_wb_dest;
    assign wb_data    = r_wb_data;
    assign wb_control = r_wb_control;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases followed by randomized instruction
// streams checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    control_in = '0;
    logic [DW-1:0] result_in = '0;
    logic [DW-1:0] store_data_in = '0;
    logic [4:0]    dest_index_in = '0;
    logic          reg_write_en_in = 1'b0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          stall;
    logic          wb_valid;
    logic          wb_we;
    logic [4:0]    wb_dest;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_control;
    logic          mem_err;

    mem_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .control_in(control_in), .result_in(result_in),
        .store_data_in(store_data_in), .dest_index_in(dest_index_in),
        .reg_write_en_in(reg_write_en_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_control(wb_control), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] c, input logic [DW-1:0] r, input logic [DW-1:0] sd,
                         input logic [4:0] d, input logic we);
        control_in      = c;
        result_in       = r;
        store_data_in   = sd;
        dest_index_in   = d;
        reg_write_en_in = we;
    endtask

    // Non-memory op: one-cycle pass-through; a stray ack while idle is ignored.
    task automatic do_alu(input logic [4:0] c, input logic [DW-1:0] r, input logic [4:0] d,
                          input logic we, input logic stray_ack);
        logic exp_v;
        drive(c, r, DW'($urandom), d, we);
        dmem_ack   = stray_ack;
        dmem_rdata = DW'($urandom);
        exp_v = (c[3:0] != 4'b0000);
        tick();
        dmem_ack = 1'b0;
        check("alu_valid", 32'(wb_valid), 32'(exp_v));
        check("alu_we", 32'(wb_we), 32'(we & exp_v));
        check("alu_dest", 32'(wb_dest), 32'(d));
        check("alu_data", 32'(wb_data), 32'(r));
        check("alu_ctrl", 32'(wb_control), 32'(c));
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_req", 32'(dmem_req), 32'd0);
        check("alu_err", 32'(mem_err), 32'd0);
    endtask

    // Memory op answered after lat ACCESS cycles (ack during the lat-th cycle).
    task automatic do_mem(input logic st, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [4:0] d, input logic we, input int lat,
                          input logic [DW-1:0] rd);
        logic [4:0] c;
        c = {1'($urandom), (st ? 4'b1110 : 4'b1100)};
        drive(c, addr, wd, d, we);
        dmem_ack = 1'b0;
        tick();
        check("mem_req", 32'(dmem_req), 32'd1);
        check("mem_we", 32'(dmem_we), 32'(st));
        check("mem_addr", 32'(dmem_addr), 32'(addr[AW-1:0]));
        if (st) check("mem_wdata", 32'(dmem_wdata), 32'(wd));
        check("mem_stall", 32'(stall), 32'd1);
        check("mem_wbv_issue", 32'(wb_valid), 32'd0);
        check("mem_wbwe_issue", 32'(wb_we), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            // Inputs are not sampled while the access is outstanding.
            drive(5'($urandom), DW'($urandom), DW'($urandom), 5'($urandom), 1'($urandom));
            if (k == lat) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end else begin
                dmem_rdata = DW'($urandom);
            end
            tick();
            dmem_ack = 1'b0;
            if (k < lat) begin
                check("hold_req", 32'(dmem_req), 32'd1);
                check("hold_we", 32'(dmem_we), 32'(st));
                check("hold_addr", 32'(dmem_addr), 32'(addr[AW-1:0]));
                if (st) check("hold_wdata", 32'(dmem_wdata), 32'(wd));
                check("hold_stall", 32'(stall), 32'd1);
                check("hold_wbv", 32'(wb_valid), 32'd0);
            end else begin
                check("done_req", 32'(dmem_req), 32'd0);
                check("done_stall", 32'(stall), 32'd0);
                check("done_valid", 32'(wb_valid), 32'd1);
                check("done_we", 32'(wb_we), st ? 32'd0 : 32'(we));
                check("done_dest", 32'(wb_dest), 32'(d));
                check("done_ctrl", 32'(wb_control), 32'(c));
                check("done_data", 32'(wb_data), st ? 32'(addr[AW-1:0]) : 32'(rd));
                check("done_err", 32'(mem_err), 32'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_memwe"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, 32'(dmem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        check({tag, "_wbwe"}, 32'(wb_we), 32'd0);
        check({tag, "_dest"}, 32'(wb_dest), 32'd0);
        check({tag, "_data"}, 32'(wb_data), 32'd0);
        check({tag, "_ctrl"}, 32'(wb_control), 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'd0);
    endtask

    function automatic logic [4:0] rand_alu_ctrl();
        logic [4:0] c;
        c = 5'($urandom);
        while (c[3:0] == 4'b1100 || c[3:0] == 4'b1110) c = 5'($urandom);
        return c;
    endfunction

    initial begin
        int max_lat;
`ifdef MEM_TIMEOUT_EN
        max_lat = TMO;
`else
        max_lat = 6;
`endif
        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Directed cases from the test plan.
        do_alu(5'b00010, 16'h1234, 5'd3, 1'b1, 1'b0);
        do_mem(1'b0, 16'h0040, 16'h0000, 5'd7, 1'b1, 3, 16'hBEEF);
        do_mem(1'b1, 16'h0010, 16'hA5A5, 5'd9, 1'b1, 1, 16'h0000);
        do_alu(5'b00000, 16'h5555, 5'd1, 1'b1, 1'b1);
        // Back-to-back loads: req low for exactly the one cycle between them.
        do_mem(1'b0, 16'h0100, 16'h0, 5'd4, 1'b1, 1, 16'h1111);
        do_mem(1'b0, 16'h0102, 16'h0, 5'd5, 1'b1, 1, 16'h2222);
        do_mem(1'b0, 16'h0104, 16'h0, 5'd6, 1'b0, 2, 16'h3333);

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_alu(rand_alu_ctrl(), DW'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            else
                do_mem(1'($urandom), DW'($urandom), DW'($urandom), 5'($urandom), 1'($urandom),
                       $urandom_range(1, max_lat), DW'($urandom));
        end

`ifdef MEM_TIMEOUT_EN
        // No acknowledge: abort after TMO ACCESS cycles.
        drive(5'b01100, 16'h0080, 16'h0, 5'd12, 1'b1);
        tick();
        check("tmo_req_issue", 32'(dmem_req), 32'd1);
        drive(5'b00000, 16'h0, 16'h0, 5'd0, 1'b0);
        for (int k = 1; k < TMO; k++) begin
            tick();
            check("tmo_wait_req", 32'(dmem_req), 32'd1);
            check("tmo_wait_err", 32'(mem_err), 32'd0);
        end
        tick();
        check("tmo_err", 32'(mem_err), 32'd1);
        check("tmo_valid", 32'(wb_valid), 32'd1);
        check("tmo_we", 32'(wb_we), 32'd0);
        check("tmo_req", 32'(dmem_req), 32'd0);
        check("tmo_stall", 32'(stall), 32'd0);
        tick();
        check("tmo_err_clear", 32'(mem_err), 32'd0);
`endif

        // Asynchronous reset in the middle of an access.
        drive(5'b01100, 16'h0200, 16'h0, 5'd8, 1'b1);
        tick();
        check("rst_pre_req", 32'(dmem_req), 32'd1);
        drive(5'b00000, 16'h0, 16'h0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hDEAD;
        tick();
        dmem_ack = 1'b0;
        check("rst_post_valid", 32'(wb_valid), 32'd0);
        check("rst_post_stall", 32'(stall), 32'd0);
        check("rst_post_req", 32'(dmem_req), 32'd0);
        check("rst_post_data", 32'(wb_data), 32'd0);
        do_mem(1'b0, 16'h0300, 16'h0, 5'd2, 1'b1, 2, 16'hC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; consumes its latched control, result, store data, destination index and write enable.
- LOAD/STORE ops drive a variable-latency data-memory request/acknowledge interface and stall upstream until complete.
- All other ops pass through with one cycle of latency.
- Registered outputs feed the writeback stage and the decode-stage forwarding path.

Parameters:
- DATA_W, 16, datapath and memory word width
- ADDR_W, 16, data-memory address width; address = low ADDR_W bits of result_in
- TIMEOUT_CYCLES, 15, cycles waited for dmem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- control_in  in  5  opcode from execute; bits [3:0] decoded, bit 4 ignored; LOAD=4'b1100, STORE=4'b1110, NOP=4'b0000
- result_in  in  DATA_W  ALU result; memory address for LOAD/STORE
- store_data_in  in  DATA_W  STORE write data
- dest_index_in  in  5  destination register index
- reg_write_en_in  in  1  destination write enable from execute
- dmem_req  out  1  memory request, held until acknowledged
- dmem_we  out  1  1 = write (STORE), 0 = read (LOAD)
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- stall  out  1  1 = upstream must hold its outputs
- wb_valid  out  1  wb_* hold a completed instruction this cycle
- wb_we  out  1  register-file write enable
- wb_dest  out  5  destination index
- wb_data  out  DATA_W  writeback value
- wb_control  out  5  opcode passed to writeback
- mem_err  out  1  one-cycle pulse on access timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0, including dmem_req, stall, wb_*, mem_err. Takes effect immediately, including mid-access; the pending access is discarded without writeback.
- FSM states: IDLE, ACCESS. stall = (state==ACCESS), decoded from the state register.
- IDLE, opcode not LOAD/STORE:
  - next edge: wb_valid = (control_in[3:0]!=NOP), wb_we = reg_write_en_in & wb_valid, wb_dest = dest_index_in, wb_data = result_in, wb_control = control_in.
  - Latency 1 cycle.
- IDLE, LOAD or STORE:
  - next edge: capture opcode/dest/write enable; dmem_req=1, dmem_we=(STORE), dmem_addr=result_in[ADDR_W-1:0], dmem_wdata=store_data_in; state -> ACCESS; wb_valid=0, wb_we=0.
- ACCESS:
  - dmem_req/we/addr/wdata held stable; stall=1; wb_valid=0, wb_we=0.
  - On edge with dmem_ack=1: dmem_req=0; state -> IDLE; wb_valid=1; wb_dest and wb_control from capture.
  - LOAD completion: wb_we = captured write enable, wb_data = dmem_rdata.
  - STORE completion: wb_we=0, wb_data = captured address zero-extended to DATA_W.
  - Minimum memory-op latency 2 cycles (ack in the first ACCESS cycle).
- dmem_ack while IDLE: ignored.
- Inputs during ACCESS are not sampled; upstream holds them, and the first IDLE cycle after completion samples the held instruction.
- Back-to-back memory ops: at least one IDLE cycle between consecutive requests; dmem_req deasserts for at least 1 cycle.
- Width: ADDR_W < DATA_W truncates the upper address bits; ADDR_W > DATA_W zero-extends.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8-bit wait counter, cleared on entering ACCESS, increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: dmem_req=0, state -> IDLE, wb_valid=1 with wb_we=0, mem_err=1 for exactly one cycle.
  - Ack and timeout on the same edge: ack wins, mem_err=0.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Test Plan:
- ADD pass-through: control_in=4'b0010, result_in=16'h1234, dest=5'd3, we=1 -> next cycle wb_valid=1, wb_we=1, wb_dest=3, wb_data=16'h1234, stall=0.
- LOAD, ack after 3 cycles: result_in=16'h0040, dmem_rdata=16'hBEEF, dest=5'd7 -> dmem_req=1, dmem_we=0, dmem_addr=16'h0040 held 3 cycles, stall=1; then wb_valid=1, wb_we=1, wb_dest=7, wb_data=16'hBEEF, stall=0.
- STORE, immediate ack: result_in=16'h0010, store_data_in=16'hA5A5 -> dmem_we=1, dmem_wdata=16'hA5A5; completes after 2 cycles with wb_we=0.
- Reset mid-access: rst_n low during ACCESS -> dmem_req, stall and wb_* drop to 0 without waiting for a clock edge; after release, state=IDLE and a later ack is ignored.
- Back-to-back LOAD, LOAD with ack in the first ACCESS cycle -> dmem_req low for exactly 1 cycle between requests; two wb_valid pulses with the correct data.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> after 4 ACCESS cycles: mem_err=1 for 1 cycle, wb_valid=1, wb_we=0, dmem_req=0, stall=0.
